// File: rtl/led_controller_n.sv
// led_controller_n: NUM_LEDS-channel PWM LED driver with per-LED mode select
// and a shared group dim/blink gate, configured over a simple register bus.
// Duty values are double-buffered and only committed at PWM period boundaries.
// Optional feature macro: LED_AUTOINC_EN adds MODE.AI (bit1), an address
// auto-increment pointer for burst register access.
module led_controller_n #(
  parameter int NUM_LEDS  = 8,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk_400K,
  input  logic                 reset,
  input  logic                 sleep,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 w_en,
  input  logic                 r_en,
  output logic [DATA_BITS-1:0] rdata,
  output logic [NUM_LEDS-1:0]  leds
);

  localparam int NUM_LO   = (NUM_LEDS + 3) / 4;
  localparam int PWM_BASE = 3;
  localparam int LO_BASE  = PWM_BASE + NUM_LEDS;
  localparam int NUM_REGS = LO_BASE + NUM_LO;
  localparam logic [DATA_BITS-1:0] ALL_ONES = '1;

  // Bus handshake: w_en and r_en are single-cycle strobes sampled on the
  // rising edge with no back-pressure (the block is always ready). A write
  // updates its register for the following cycle. A read-only strobe loads
  // rdata, which is valid from the next cycle and holds until the next
  // read-only strobe. With both strobes high, only the write takes effect.

  logic                 dmblnk_q;
  logic [DATA_BITS-1:0] grppwm_q;
  logic [DATA_BITS-1:0] grpfreq_q;
  logic [DATA_BITS-1:0] pwm_q    [NUM_LEDS];
  logic [DATA_BITS-1:0] sh_pwm_q [NUM_LEDS];
  logic [DATA_BITS-1:0] ledout_q [NUM_LO];
  logic [DATA_BITS-1:0] sh_grp_q;
  logic [DATA_BITS-1:0] pcnt_q, pcnt_d;
  logic [DATA_BITS-1:0] pre_q, pre_d;
  logic [DATA_BITS-1:0] gcnt_q, gcnt_d;
  logic [DATA_BITS-1:0] limit;
  logic [DATA_BITS-1:0] rdata_q, rd_val;
  logic [NUM_LEDS-1:0]  leds_q, led_d;
  logic [ADDR_BITS-1:0] eff_addr;
  logic [31:0]          eff_idx;
  logic                 boundary;
  logic                 gate;

`ifdef LED_AUTOINC_EN
  logic                 ai_q;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [ADDR_BITS-1:0] last_addr_q;
  logic                 last_vld_q;
  logic                 use_ptr;

  // Repeated accesses to the same address walk through the map via the pointer.
  assign use_ptr  = ai_q && last_vld_q && (addr == last_addr_q);
  assign eff_addr = use_ptr ? ptr_q : addr;
  assign ptr_d    = (32'(eff_addr) >= 32'(NUM_REGS - 1)) ? '0 : eff_addr + ADDR_BITS'(1);

  // Remember the last strobed address and advance the burst pointer.
  always_ff @(posedge clk_400K or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      last_addr_q <= '0;
      last_vld_q  <= 1'b0;
    end else if (w_en || r_en) begin
      ptr_q       <= ptr_d;
      last_addr_q <= addr;
      last_vld_q  <= 1'b1;
    end
  end
`else
  assign eff_addr = addr;
`endif

  assign eff_idx  = 32'(eff_addr);
  assign boundary = !sleep && (pcnt_q == ALL_ONES);
  assign gate     = (gcnt_q < sh_grp_q);
  assign pcnt_d   = sleep ? pcnt_q : pcnt_q + DATA_BITS'(1);

  // Control register writes (MODE, GRPPWM, GRPFREQ) and shadow group duty.
  always_ff @(posedge clk_400K or posedge reset) begin
    if (reset) begin
      dmblnk_q  <= 1'b0;
`ifdef LED_AUTOINC_EN
      ai_q      <= 1'b0;
`endif
      grppwm_q  <= ALL_ONES;
      grpfreq_q <= '0;
      sh_grp_q  <= '0;
    end else begin
      if (w_en && eff_idx == 32'd0) begin
        dmblnk_q <= wdata[0];
`ifdef LED_AUTOINC_EN
        ai_q     <= wdata[1];
`endif
      end
      if (w_en && eff_idx == 32'd1) grppwm_q  <= wdata;
      if (w_en && eff_idx == 32'd2) grpfreq_q <= wdata;
      if (boundary)                 sh_grp_q  <= grppwm_q;
    end
  end

  // Per-LED duty and mode registers; duties copy into shadows at each boundary.
  always_ff @(posedge clk_400K or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        pwm_q[i]    <= '0;
        sh_pwm_q[i] <= '0;
      end
      for (int k = 0; k < NUM_LO; k++) ledout_q[k] <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (w_en && eff_idx == 32'(PWM_BASE + i)) pwm_q[i] <= wdata;
        if (boundary) sh_pwm_q[i] <= pwm_q[i];
      end
      for (int k = 0; k < NUM_LO; k++) begin
        if (w_en && eff_idx == 32'(LO_BASE + k)) ledout_q[k] <= wdata;
      end
    end
  end

  // Read mux: unmapped addresses return zero.
  always_comb begin
    rd_val = '0;
    if (eff_idx == 32'd0) begin
      rd_val[0] = dmblnk_q;
`ifdef LED_AUTOINC_EN
      rd_val[1] = ai_q;
`endif
    end
    if (eff_idx == 32'd1) rd_val = grppwm_q;
    if (eff_idx == 32'd2) rd_val = grpfreq_q;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (eff_idx == 32'(PWM_BASE + i)) rd_val = pwm_q[i];
    end
    for (int k = 0; k < NUM_LO; k++) begin
      if (eff_idx == 32'(LO_BASE + k)) rd_val = ledout_q[k];
    end
  end

  // Registered read data, loaded only on a read without a concurrent write.
  always_ff @(posedge clk_400K or posedge reset) begin
    if (reset) rdata_q <= '0;
    else if (r_en && !w_en) rdata_q <= rd_val;
  end

  // Group prescaler: dim mode steps gcnt every period, blink every GRPFREQ+1 periods.
  always_comb begin
    limit  = dmblnk_q ? grpfreq_q : '0;
    pre_d  = pre_q;
    gcnt_d = gcnt_q;
    if (boundary) begin
      if (pre_q == limit) begin
        pre_d  = '0;
        gcnt_d = gcnt_q + DATA_BITS'(1);
      end else begin
        pre_d  = pre_q + DATA_BITS'(1);
      end
    end
  end

  // Free-running PWM counter plus group counters; all freeze while asleep.
  always_ff @(posedge clk_400K or posedge reset) begin
    if (reset) begin
      pcnt_q <= '0;
      pre_q  <= '0;
      gcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      pre_q  <= pre_d;
      gcnt_q <= gcnt_d;
    end
  end

  // Per-LED mode decode: 00 off, 01 on, 10 individual PWM, 11 PWM gated by group.
  for (genvar n = 0; n < NUM_LEDS; n++) begin : g_chan
    logic [1:0] sel;
    logic       ind;
    assign sel      = ledout_q[n / 4][2 * (n % 4) +: 2];
    assign ind      = (pcnt_q < sh_pwm_q[n]);
    assign led_d[n] = (sel == 2'b01) || (sel == 2'b10 && ind) || (sel == 2'b11 && ind && gate);
  end

  // Registered LED drive, forced off while asleep.
  always_ff @(posedge clk_400K or posedge reset) begin
    if (reset) leds_q <= '0;
    else if (sleep) leds_q <= '0;
    else leds_q <= led_d;
  end

  assign rdata = rdata_q;
  assign leds  = leds_q;

endmodule

// File: tb/tb_led_controller_n.sv
// Testbench for led_controller_n: directed bus and LED vectors with a
// queue-based scoreboard; a monitor compares whenever rdata or leds are due.
`timescale 1ns/1ps
module tb_led_controller_n;

  localparam int NL = 8;
  localparam int DB = 8;
  localparam int AB = 6;

  // ---------------- clock / reset ----------------
  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          sleep = 1'b0;
  logic          w_en  = 1'b0;
  logic          r_en  = 1'b0;
  logic [AB-1:0] addr  = '0;
  logic [DB-1:0] wdata = '0;
  logic [DB-1:0] rdata;
  logic [NL-1:0] leds;

  always #5 clk = ~clk;

  led_controller_n #(.NUM_LEDS(NL), .DATA_BITS(DB), .ADDR_BITS(AB)) dut (
    .clk_400K (clk),
    .reset    (rst),
    .sleep    (sleep),
    .addr     (addr),
    .wdata    (wdata),
    .w_en     (w_en),
    .r_en     (r_en),
    .rdata    (rdata),
    .leds     (leds)
  );

  // ---------------- scoreboard state ----------------
  logic [DB-1:0] exp_q[$];
  string         rd_name_q[$];
  logic [NL-1:0] led_exp_q[$];
  string         led_name_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DB-1:0] last_rd  = '0;
  logic          led_req  = 1'b0;
  logic          rd_chk, led_chk;

  // Strobes marking cycles in which the DUT presents a response.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_chk  <= 1'b0;
      led_chk <= 1'b0;
    end else begin
      rd_chk  <= r_en;
      led_chk <= led_req;
    end
  end

  // Reference period/boundary counters derived from reset and sleep only.
  int unsigned tb_pcnt, tb_bnd;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_pcnt <= 0;
      tb_bnd  <= 0;
    end else if (!sleep) begin
      if (tb_pcnt == 255) tb_bnd <= tb_bnd + 1;
      tb_pcnt <= (tb_pcnt + 1) % 256;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rd_chk) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got %h expected no response", rdata);
      end else begin
        logic [DB-1:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = rd_name_q.pop_front();
        if (rdata !== e) begin
          n_fail++;
          $display("FAIL %s: rdata got %h expected %h", nm, rdata, e);
        end
      end
    end
    if (led_chk) begin
      n_checks++;
      if (led_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL led_unexpected: got %b expected no response", leds);
      end else begin
        logic [NL-1:0] e;
        string nm;
        e  = led_exp_q.pop_front();
        nm = led_name_q.pop_front();
        if (leds !== e) begin
          n_fail++;
          $display("FAIL %s: leds got %b expected %b", nm, leds, e);
        end
      end
    end
  end

  // ---------------- driver tasks (entered just after a negedge) ----------------
  task automatic bus_write(input int a, input int d);
    addr = AB'(a); wdata = DB'(d); w_en = 1'b1; r_en = 1'b0;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic bus_read(input int a, input int e, input string nm);
    addr = AB'(a); w_en = 1'b0; r_en = 1'b1;
    exp_q.push_back(DB'(e)); rd_name_q.push_back(nm);
    last_rd = DB'(e);
    @(negedge clk);
    r_en = 1'b0;
  endtask

  task automatic bus_wr_rd(input int a, input int d, input string nm);
    addr = AB'(a); wdata = DB'(d); w_en = 1'b1; r_en = 1'b1;
    exp_q.push_back(last_rd); rd_name_q.push_back(nm);
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic led_check_now(input int e, input string nm);
    led_req = 1'b1;
    led_exp_q.push_back(NL'(e)); led_name_q.push_back(nm);
    @(negedge clk);
    led_req = 1'b0;
  endtask

  task automatic wait_pcnt(input int p);
    int guard = 0;
    while (tb_pcnt != p && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (tb_pcnt != p) begin
      n_checks++; n_fail++;
      $display("FAIL wait_pcnt: got %0d expected %0d", tb_pcnt, p);
    end
  endtask

  task automatic wait_bnd(input int b);
    int guard = 0;
    while (tb_bnd != b && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (tb_bnd != b) begin
      n_checks++; n_fail++;
      $display("FAIL wait_bnd: got %0d expected %0d", tb_bnd, b);
    end
  endtask

  // Request a LED sample computed from PWM count p.
  task automatic led_check_at(input int p, input int e, input string nm);
    wait_pcnt(p);
    led_check_now(e, nm);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset values.
    led_check_now(8'h00, "reset_leds");
    for (int a = 0; a < 13; a++) bus_read(a, (a == 1) ? 8'hFF : 8'h00, $sformatf("reset_reg%0d", a));

    // Individual PWM: commit waits for the period boundary.
    bus_write(3, 8'h40);
    bus_write(11, 8'h02);
    bus_read(3, 8'h40, "pwm0_rd");
    led_check_at(200, 8'h00, "pre_commit");
    led_check_at(0,   8'h01, "first_after_wrap");
    led_check_at(63,  8'h01, "duty40_last_on");
    led_check_at(64,  8'h00, "duty40_first_off");

    // Dim mode: LED0 fully on, LED1 PWM gated by group duty 0x20.
    bus_write(4, 8'h80);
    bus_write(11, 8'h0D);
    bus_write(1, 8'h20);
    bus_write(0, 8'h00);
    led_check_at(100, 8'h01, "ledout_immediate");
    led_check_at(10,   8'h03, "dim_gate_on");
    led_check_at(8'h7F, 8'h03, "duty80_last_on");
    led_check_at(8'h80, 8'h01, "duty80_first_off");

    // Sleep mid-pulse: LEDs off next edge, registers accessible, counter held.
    wait_pcnt(8'h30);
    sleep = 1'b1;
    led_check_now(8'h00, "sleep_off");
    bus_write(5, 8'hC0);
    bus_read(5, 8'hC0, "sleep_pwm2_rd");
    led_check_now(8'h00, "sleep_hold");
    repeat (5) @(negedge clk);
    sleep = 1'b0;
    led_check_at(8'h7F, 8'h03, "resume_last_on");
    led_check_at(8'h80, 8'h01, "resume_first_off");

    // Group gate stays on through gcnt 0x1F and turns off at 0x20.
    wait_bnd(8'h1F);
    led_check_at(10, 8'h03, "dim_gate_last_on");
    wait_bnd(8'h20);
    led_check_at(10, 8'h01, "dim_gate_off");

    // Bus corner cases.
    bus_wr_rd(6, 8'hFF, "wr_rd_hold");
    bus_read(6, 8'hFF, "pwm3_rd");
    bus_read(13, 8'h00, "invalid_13");
    bus_write(40, 8'h55);
    bus_read(40, 8'h00, "invalid_40");
    bus_read(63, 8'h00, "invalid_63");
`ifndef LED_AUTOINC_EN
    bus_write(0, 8'h03);
    bus_read(0, 8'h01, "mode_bit1_zero");
    bus_write(0, 8'h00);
`endif

    // Reset mid-pulse: outputs clear immediately.
    bus_read(6, 8'hFF, "pre_reset_rd");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (leds !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_leds: got %b expected %b", leds, 8'h00);
    end
    n_checks++;
    if (rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_rdata: got %h expected %h", rdata, 8'h00);
    end
    last_rd = 8'h00;
    @(negedge clk);
    rst = 1'b0;

    // Blink mode: GRPFREQ=1 so gcnt steps every 2 periods; gate = gcnt < 2.
    bus_write(0, 8'h01);
    bus_write(2, 8'h01);
    bus_write(1, 8'h02);
    bus_write(3, 8'hFF);
    bus_write(11, 8'h03);
    wait_bnd(1);
    led_check_at(5,   8'h01, "blink_step0_on");
    led_check_at(255, 8'h00, "dutyff_last_off");
    wait_bnd(3);
    led_check_at(5,   8'h01, "blink_step1_on");
    wait_bnd(4);
    led_check_at(5,   8'h00, "blink_step2_off");

`ifdef LED_AUTOINC_EN
    // Burst load PWM0..PWM7 through the auto-increment pointer.
    bus_write(0, 8'h02);
    for (int i = 0; i < 8; i++) bus_write(3, 8'h11 * (i + 1));
    bus_write(0, 8'h00);
    for (int i = 0; i < 8; i++) bus_read(3 + i, 8'h11 * (i + 1), $sformatf("ai_pwm%0d", i));
    bus_read(0, 8'h00, "ai_mode_off");
`endif

    // Drain: every expected response must have been consumed.
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || led_exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_q.size(), led_exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
